// File: rtl/jump_pipe.sv
// Branch resolve pipeline: opcode issued at edge n resolves in stage DEPTH-1 after edge n+DEPTH-1.
// stall freezes every stage and counter; a taken branch flushes all stages including the incoming slot.
module jump_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 16,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [2:0]    jump_inst,
  input  logic [AW-1:0] jump_addr_in,
  input  logic          jump_pred_busy,
  input  logic          S_wb,
  input  logic          Z_wb,
  input  logic          C_wb,
  input  logic          V_wb,
  input  logic          cnt_clr,
  output logic [2:0]    jump_state,
  output logic          jump,
  output logic [AW-1:0] jump_addr,
  output logic          squash,
  output logic [CW-1:0] br_cnt,
  output logic [CW-1:0] taken_cnt
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_B    = 3'd1;
  localparam logic [2:0] OP_BE   = 3'd2;
  localparam logic [2:0] OP_BLT  = 3'd3;
  localparam logic [2:0] OP_BLE  = 3'd4;
  localparam logic [2:0] OP_BNE  = 3'd5;
  localparam logic [2:0] OP_BCS  = 3'd6;
  localparam logic [2:0] OP_BGE  = 3'd7;

  logic [2:0]    op_q   [DEPTH];
  logic [2:0]    op_d   [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [CW-1:0] br_cnt_q, br_cnt_d;
  logic [CW-1:0] taken_cnt_q, taken_cnt_d;
  logic          cond_c;
  logic          sv_c;

  always_comb begin
    sv_c = S_wb ^ V_wb;
    case (op_q[DEPTH-1])
      OP_B:    cond_c = 1'b1;
      OP_BE:   cond_c = Z_wb;
      OP_BLT:  cond_c = sv_c;
      OP_BLE:  cond_c = Z_wb | sv_c;
      OP_BNE:  cond_c = ~Z_wb;
      OP_BCS:  cond_c = C_wb;
      OP_BGE:  cond_c = ~sv_c;
      default: cond_c = 1'b0;
    endcase
  end

  // Resolution is withheld during stall so the flags seen on release decide.
  assign jump       = ~stall & cond_c;
  assign squash     = jump;
  assign jump_state = op_q[DEPTH-1];
  assign jump_addr  = addr_q[DEPTH-1];
  assign br_cnt     = br_cnt_q;
  assign taken_cnt  = taken_cnt_q;

  always_comb begin
    op_d   = op_q;
    addr_d = addr_q;
    if (!stall) begin
      if (jump) begin
        for (int i = 0; i < DEPTH; i++) begin
          op_d[i]   = OP_NONE;
          addr_d[i] = '0;
        end
      end else begin
        op_d[0]   = jump_pred_busy ? OP_NONE : jump_inst;
        addr_d[0] = jump_pred_busy ? '0 : jump_addr_in;
        for (int i = 1; i < DEPTH; i++) begin
          op_d[i]   = op_q[i-1];
          addr_d[i] = addr_q[i-1];
        end
      end
    end
  end

  always_comb begin
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (cnt_clr) begin
      br_cnt_d    = '0;
      taken_cnt_d = '0;
    end else if (!stall) begin
      if (op_q[DEPTH-1] != OP_NONE) br_cnt_d = br_cnt_q + CW'(1);
      if (jump) taken_cnt_d = taken_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= OP_NONE;
        addr_q[i] <= '0;
      end
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      op_q        <= op_d;
      addr_q      <= addr_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_jump_pipe.sv
// Directed plus random bench for jump_pipe: DEPTH=2/CW=16 and DEPTH=1/CW=4 instances share all inputs.
module tb_jump_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  jump_inst;
  logic [15:0] jump_addr_in;
  logic        jump_pred_busy;
  logic        S_wb, Z_wb, C_wb, V_wb;
  logic        cnt_clr;

  logic [2:0]  jump_state0, jump_state1;
  logic        jump0, jump1, squash0, squash1;
  logic [15:0] jump_addr0, jump_addr1;
  logic [15:0] br_cnt0, taken_cnt0;
  logic [3:0]  br_cnt1, taken_cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jump_pipe #(.DEPTH(2), .AW(16), .CW(16)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .jump_inst(jump_inst),
    .jump_addr_in(jump_addr_in), .jump_pred_busy(jump_pred_busy),
    .S_wb(S_wb), .Z_wb(Z_wb), .C_wb(C_wb), .V_wb(V_wb), .cnt_clr(cnt_clr),
    .jump_state(jump_state0), .jump(jump0), .jump_addr(jump_addr0),
    .squash(squash0), .br_cnt(br_cnt0), .taken_cnt(taken_cnt0)
  );

  jump_pipe #(.DEPTH(1), .AW(16), .CW(4)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .jump_inst(jump_inst),
    .jump_addr_in(jump_addr_in), .jump_pred_busy(jump_pred_busy),
    .S_wb(S_wb), .Z_wb(Z_wb), .C_wb(C_wb), .V_wb(V_wb), .cnt_clr(cnt_clr),
    .jump_state(jump_state1), .jump(jump1), .jump_addr(jump_addr1),
    .squash(squash1), .br_cnt(br_cnt1), .taken_cnt(taken_cnt1)
  );

  // Reference model: one in-flight list per instance, index 0 = youngest.
  int dep  [2] = '{2, 1};
  int cmask[2] = '{32'hFFFF, 32'hF};
  int mop  [2][8];
  int maddr[2][8];
  int mbr  [2];
  int mtk  [2];

  function automatic bit cond_taken(int op, bit s, bit z, bit c, bit v);
    bit lt;
    lt = (s != v);
    case (op)
      1: return 1'b1;
      2: return z;
      3: return lt;
      4: return z || lt;
      5: return !z;
      6: return c;
      7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_jump(int m);
    return !stall && cond_taken(mop[m][dep[m]-1], S_wb, Z_wb, C_wb, V_wb);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 8; i++) begin
        mop[m][i]   = 0;
        maddr[m][i] = 0;
      end
      mbr[m] = 0;
      mtk[m] = 0;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit j;
      int d;
      d = dep[m];
      j = model_jump(m);
      if (cnt_clr) begin
        mbr[m] = 0;
        mtk[m] = 0;
      end else if (!stall) begin
        if (mop[m][d-1] != 0) mbr[m] = (mbr[m] + 1) & cmask[m];
        if (j) mtk[m] = (mtk[m] + 1) & cmask[m];
      end
      if (!stall) begin
        if (j) begin
          for (int i = 0; i < d; i++) begin
            mop[m][i]   = 0;
            maddr[m][i] = 0;
          end
        end else begin
          for (int i = d - 1; i > 0; i--) begin
            mop[m][i]   = mop[m][i-1];
            maddr[m][i] = maddr[m][i-1];
          end
          mop[m][0]   = jump_pred_busy ? 0 : int'(jump_inst);
          maddr[m][0] = jump_pred_busy ? 0 : int'(jump_addr_in);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("state0",  32'(jump_state0), 32'(mop[0][1]));
    chk("jump0",   32'(jump0),       32'(model_jump(0)));
    chk("squash0", 32'(squash0),     32'(model_jump(0)));
    chk("addr0",   32'(jump_addr0),  32'(maddr[0][1]));
    chk("br0",     32'(br_cnt0),     32'(mbr[0]));
    chk("tk0",     32'(taken_cnt0),  32'(mtk[0]));
    chk("state1",  32'(jump_state1), 32'(mop[1][0]));
    chk("jump1",   32'(jump1),       32'(model_jump(1)));
    chk("squash1", 32'(squash1),     32'(model_jump(1)));
    chk("addr1",   32'(jump_addr1),  32'(maddr[1][0]));
    chk("br1",     32'(br_cnt1),     32'(mbr[1]));
    chk("tk1",     32'(taken_cnt1),  32'(mtk[1]));
  endtask

  // Drive one cycle of inputs, check against the model, then clock.
  task automatic step(input logic [2:0] inst, input logic [15:0] a, input logic busy,
                      input logic st, input logic fs, input logic fz, input logic fc,
                      input logic fv, input logic clr);
    jump_inst = inst; jump_addr_in = a; jump_pred_busy = busy; stall = st;
    S_wb = fs; Z_wb = fz; C_wb = fc; V_wb = fv; cnt_clr = clr;
    #1;
    compare_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic fs, input logic fz, input logic fc, input logic fv);
    step(3'd0, 16'h0, 1'b0, 1'b0, fs, fz, fc, fv, 1'b0);
  endtask

  initial begin
    int br_before, tk_before;
    reset = 1'b0; stall = 1'b0; jump_inst = 3'd0; jump_addr_in = 16'h0;
    jump_pred_busy = 1'b0; S_wb = 1'b0; Z_wb = 1'b0; C_wb = 1'b0; V_wb = 1'b0;
    cnt_clr = 1'b0;
    model_reset();
    #2;
    chk("rst_state", 32'(jump_state0), 32'd0);
    chk("rst_jump",  32'(jump0),       32'd0);
    chk("rst_tk",    32'(taken_cnt0),  32'd0);
    compare_all();
    #5 reset = 1'b1;

    // Unconditional branch: resolves after one more edge, flushes on the next.
    step(3'd1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_state_early", 32'(jump_state0), 32'd0);
    idle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_state", 32'(jump_state0), 32'd1);
    chk("b_jump",  32'(jump0),       32'd1);
    chk("b_addr",  32'(jump_addr0),  32'h0040);
    idle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_flush", 32'(jump_state0), 32'd0);
    chk("b_tk",    32'(taken_cnt0),  32'd1);

    // BE then BNE with Z=1: BE taken, BNE discarded.
    br_before = int'(br_cnt0);
    step(3'd2, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3'd5, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("be_jump", 32'(jump0), 32'd1);
    idle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("bne_squashed", 32'(jump_state0), 32'd0);
    chk("be_br", 32'(br_cnt0), 32'(br_before + 1));

    // BLT held by stall, resolves once on release.
    step(3'd3, 16'h0300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0, 1'b0);
    br_before = int'(br_cnt0);
    tk_before = int'(taken_cnt0);
    for (int k = 0; k < 3; k++) begin
      step(3'd0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("blt_held_state", 32'(jump_state0), 32'd3);
      chk("blt_held_jump",  32'(jump0),       32'd0);
    end
    chk("blt_held_tk", 32'(taken_cnt0), 32'(tk_before));
    idle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("blt_tk", 32'(taken_cnt0), 32'(tk_before + 1));
    chk("blt_br", 32'(br_cnt0),    32'(br_before + 1));

    // Busy turns the issued opcode into a bubble.
    br_before = int'(br_cnt0);
    step(3'd7, 16'h0700, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("busy_state", 32'(jump_state0), 32'd0);
    idle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("busy_br", 32'(br_cnt0), 32'(br_before));

    // Counter wrap on the 4-bit DEPTH=1 instance, then clear against a taken branch.
    step(3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) step(3'd1, 16'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_pre", 32'(taken_cnt1), 32'hF);
    for (int k = 0; k < 2; k++) step(3'd1, 16'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap", 32'(taken_cnt1), 32'h0);
    step(3'd1, 16'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_pre_jump", 32'(jump1), 32'd1);
    step(3'd1, 16'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_tk", 32'(taken_cnt1), 32'd0);
    chk("clr_br", 32'(br_cnt1),    32'd0);

    // Clear while stalled.
    step(3'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_stall", 32'(br_cnt0), 32'd0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset with both stages occupied by not-yet-taken branches.
    step(3'd2, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'd6, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_state", 32'(jump_state0), 32'd2);
    #1 reset = 1'b0;
    #1;
    chk("arst_state0", 32'(jump_state0), 32'd0);
    chk("arst_addr0",  32'(jump_addr0),  32'd0);
    chk("arst_br0",    32'(br_cnt0),     32'd0);
    chk("arst_tk0",    32'(taken_cnt0),  32'd0);
    chk("arst_state1", 32'(jump_state1), 32'd0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1'b0, 1'b1, 1'b1, 1'b0);
      chk("post_rst_jump0", 32'(jump0), 32'd0);
      chk("post_rst_jump1", 32'(jump1), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jump_pipe.md
JUMP_PIPE -- requirements
Module: jump_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning issue-to-resolve delay in cycles (legal 1..8).
REQ-002 SHALL have parameter AW, default 16, meaning branch target address width.
REQ-003 SHALL have parameter CW, default 16, meaning statistics counter width.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port stall  in  1  holds every stage and counter.
REQ-007 SHALL have port jump_inst  in  3  branch opcode issued this cycle (0 = none).
REQ-008 SHALL have port jump_addr_in  in  AW  target carried alongside jump_inst.
REQ-009 SHALL have port jump_pred_busy  in  1  inserts a bubble (opcode 0) in place of jump_inst.
REQ-010 SHALL have ports S_wb, Z_wb, C_wb, V_wb  in  1 each  write-back flags.
REQ-011 SHALL have port cnt_clr  in  1  synchronous clear of both counters.
REQ-012 SHALL have port jump_state  out  3  opcode in resolve stage (stage DEPTH-1).
REQ-013 SHALL have port jump  out  1  resolve-stage branch taken.
REQ-014 SHALL have port jump_addr  out  AW  target of resolve-stage entry.
REQ-015 SHALL have port squash  out  1  younger in-flight entries being discarded.
REQ-016 SHALL have ports br_cnt and taken_cnt  out  CW each  resolved-branch and taken-branch counts.

Function
REQ-017 SHALL hold DEPTH stages, each {op[2:0], addr[AW-1:0]}; stage 0 youngest, stage DEPTH-1 resolve stage.
REQ-018 SHALL, per non-stalled edge without taken jump: stage0 <= busy ? {0,0} : {jump_inst, jump_addr_in}; stage i <= stage i-1.
REQ-019 SHALL decode resolve-stage op combinationally: 1 B ->1; 2 BE ->Z; 3 BLT ->S^V; 4 BLE ->Z|(S^V); 5 BNE ->!Z; 6 BCS ->C; 7 BGE ->!(S^V); 0 ->0.
REQ-020 SHALL force jump=0 while stall=1; resolution deferred to first non-stalled cycle with flags then present.
REQ-021 SHALL drive squash = jump.
REQ-022 SHALL, on a non-stalled edge with jump=1, load opcode 0 and address 0 into all stages, including the incoming jump_inst.
REQ-023 SHALL drive jump_state and jump_addr directly from the resolve stage regardless of stall.
REQ-024 SHALL increment br_cnt on each non-stalled edge where resolve op != 0.
REQ-025 SHALL increment taken_cnt on each non-stalled edge where jump=1.
REQ-026 SHALL wrap both counters modulo 2^CW, with no saturation.
REQ-027 SHALL give cnt_clr priority over increment; cnt_clr acts even under stall; pipeline unaffected.
REQ-028 SHALL have latency: opcode issued at edge n appears in jump_state after edge n+DEPTH-1 (no stall/squash).
REQ-029 SHALL, when jump_pred_busy and stall are both 1, hold (stall wins).
REQ-030 SHALL, for DEPTH=1, make jump_inst resolve one cycle after issue with the same squash rule.

Reset
REQ-031 SHALL, with reset low, asynchronously clear all stages and both counters; outputs jump_state=0, jump=0, squash=0, jump_addr=0, br_cnt=0, taken_cnt=0.
REQ-032 SHALL, on reset assertion mid-operation, discard in-flight branches, with no resolution on reset release.
REQ-033 SHALL make the first capture occur on the first rising edge with reset high.

Verification (DEPTH=2, AW=16, CW=16)
REQ-034 SHALL cover: issue op1 addr 0x0040 at edge 0 -> jump_state=1, jump=1, jump_addr=0x0040 after edge 1; all stages 0 after edge 2; taken_cnt=1.
REQ-035 SHALL cover: op2 (BE), then op5 (BNE) back-to-back, Z_wb=1 -> BE taken, BNE squashed, jump_state=0 next cycle, br_cnt=1.
REQ-036 SHALL cover: op3 resolving with S=1,V=0, stall=1 for 3 cycles -> jump=0, jump_state=3 held; stall drop -> jump=1, counters +1 once.
REQ-037 SHALL cover: jump_pred_busy=1 with jump_inst=7 -> bubble, jump_state=0 two cycles later, br_cnt unchanged.
REQ-038 SHALL cover: taken_cnt preset to 0xFFFF via 65535 taken branches; one more -> 0x0000; cnt_clr with simultaneous taken -> 0.
REQ-039 SHALL cover: reset low asynchronously with ops in both stages -> all outputs 0 before next clk edge; no jump after release.
